hl_reset_sequencer: RTL
=======================

// Module: hl_reset_sequencer
// PURPOSE
//  Board-level reset/startup sequencer for the Hermes Lite top wrappers; sits between the IF PLL and hermes_lite_core.
//  Qualifies PLL lock and debounces extreset, then releases NRST reset domains in order (e.g. PHY, AD9866, core), STEP_CYCLES apart.
//  Re-sequences automatically on PLL lock loss and counts lock-loss events for status LEDs.
// PARAMETERS
//  NRST            3    number of reset domains (1..8); rst_o[0] is released first
//  STEP_CYCLES     1024 clk cycles of lock qualification and between successive releases (>=2)
//  DEBOUNCE_CYCLES 4096 consecutive stable cycles required before extreset_db changes (>=2)
//  MON_CYCLES      256  clock-monitor timeout in clk cycles (only with RSTSEQ_CLKMON_EN)
// PORTS
//  clk           in   1     sequencer clock (slowclk domain)
//  rst           in   1     synchronous active-high reset
//  pll_locked    in   1     PLL lock, asynchronous; 2-FF synchronized internally
//  extreset      in   1     external reset, active-high, asynchronous; 2-FF synced then debounced
//  mon_toggle    in   1     divided monitored-clock toggle, async; 2-FF synced (used only with RSTSEQ_CLKMON_EN)
//  rst_o         out  NRST  per-domain active-high resets
//  ready         out  1     all domains released
//  fault         out  1     high from a lock-loss/clock-loss event until the next entry to RUN
//  lockloss_cnt  out  8     saturating count of lock-loss (and clock-loss) events
// BEHAVIOUR
//  Reset values (rst=1): rst_o=all ones, ready=0, fault=0, lockloss_cnt=0, state=HOLD, idx=0, cnt=0, extreset_db=1.
//  Synchronizers: 2 flops each; all decisions use synchronized values (2-cycle input latency).
//  Debounce: extreset_db takes the synced extreset value only after it differs from extreset_db for DEBOUNCE_CYCLES
//   consecutive cycles; any glitch restarts the count.
//  FSM states HOLD, WAIT_LOCK, RELEASE, RUN:
//   HOLD: rst_o all 1, ready 0. extreset_db=0 -> WAIT_LOCK with cnt=0.
//   WAIT_LOCK: cnt counts while lock_s=1, clears when lock_s=0. At cnt==STEP_CYCLES-1 -> RELEASE, cnt=0, idx=0.
//   RELEASE: cnt counts 0..STEP_CYCLES-1; at terminal count rst_o[idx]<=0, cnt<=0, idx<=idx+1;
//    when idx==NRST-1 is released -> RUN next cycle. Released bits stay 0; bits >idx stay 1.
//   RUN: ready=1 (registered, asserted the cycle the state becomes RUN); fault<=0 on entry.
//  Lock loss: lock_s=0 in RELEASE or RUN -> next cycle rst_o all 1, ready 0, fault 1, lockloss_cnt+1
//   (saturates at 255, no wrap), state WAIT_LOCK, cnt=0. In WAIT_LOCK/HOLD lock_s=0 is not counted.
//  extreset_db=1 in any state has priority over lock loss: next cycle rst_o all 1, ready 0, state HOLD, no count change.
//  Simultaneous extreset_db rise and lock loss: HOLD, lockloss_cnt unchanged, fault unchanged.
//  Ordering guarantee: rst_o[k] never deasserts before rst_o[k-1]; any reassertion asserts all bits in the same cycle.
//  rst mid-sequence: immediate return to reset values next edge; debounce and sync flops also cleared (sync flops to 0, extreset_db to 1).
//  Total release latency from lock_s high (stable): STEP_CYCLES*(NRST+1) cycles +1 to ready.
// CONFIGURATION
//  RSTSEQ_CLKMON_EN defined: monitor counter clears on each edge (either polarity) of synced mon_toggle; in RELEASE/RUN,
//   reaching MON_CYCLES without an edge is treated exactly as lock loss (counted, fault=1, -> WAIT_LOCK);
//   WAIT_LOCK additionally requires at least one mon edge within the qualification window before RELEASE.
//  RSTSEQ_CLKMON_EN undefined: mon_toggle ignored, no monitor logic; lock loss only from pll_locked.
// TESTING (bench params NRST=3, STEP_CYCLES=4, DEBOUNCE_CYCLES=8, MON_CYCLES=16)
//  1 rst, extreset=0, pll_locked=1 -> extreset_db falls after 2+8 cycles; rst_o 111->110->100->000 at 4-cycle steps; ready 1 after last.
//  2 extreset pulses of 5 cycles every 7 cycles during RUN -> no debounce change, rst_o stays 000, ready stays 1.
//  3 pll_locked drop for 1 cycle in RUN -> rst_o 111, fault 1, lockloss_cnt 1; re-sequence completes, fault clears on RUN.
//  4 300 lock-loss events -> lockloss_cnt sticks at 255.
//  5 extreset and pll_locked drop aligned so extreset_db and lock loss hit the same cycle -> HOLD, lockloss_cnt unchanged.
//  6 RSTSEQ_CLKMON_EN: stop mon_toggle in RUN -> lock-loss response 16 cycles (+2 sync) after last edge; without macro no reaction.

Source files
------------

// File: rtl/hl_reset_sequencer.sv
// rtl/hl_reset_sequencer.sv - lock-qualified, debounced, ordered reset release; RSTSEQ_CLKMON_EN adds clock monitor
module hl_reset_sequencer #(
    parameter int NRST            = 3,
    parameter int STEP_CYCLES     = 1024,
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int MON_CYCLES      = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pll_locked,
    input  logic            extreset,
    input  logic            mon_toggle,
    output logic [NRST-1:0] rst_o,
    output logic            ready,
    output logic            fault,
    output logic [7:0]      lockloss_cnt
);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int IW = $clog2(NRST + 1);

    typedef enum logic [1:0] {HOLD, WAIT_LOCK, RELEASE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          fault_nxt, count_loss, lost, qual_ok;
    logic [NRST-1:0] rst_nxt;
    logic          ready_nxt;

    logic          lock_m, lock_s, ext_m, ext_s, ext_db;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            ext_m  <= 1'b0;
            ext_s  <= 1'b0;
            ext_db <= 1'b1;
            db_cnt <= '0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
            ext_m  <= extreset;
            ext_s  <= ext_m;
            if (ext_s == ext_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                ext_db <= ext_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

`ifdef RSTSEQ_CLKMON_EN
    localparam int MW = $clog2(MON_CYCLES + 1);
    logic          mon_m, mon_s, mon_d, mon_edge, mon_lost, mon_seen, mon_seen_nxt;
    logic [MW-1:0] mon_cnt;

    assign mon_edge = mon_s ^ mon_d;
    assign mon_lost = (mon_cnt == MW'(MON_CYCLES));
    assign qual_ok  = mon_seen | mon_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            mon_m    <= 1'b0;
            mon_s    <= 1'b0;
            mon_d    <= 1'b0;
            mon_cnt  <= '0;
            mon_seen <= 1'b0;
        end else begin
            mon_m    <= mon_toggle;
            mon_s    <= mon_m;
            mon_d    <= mon_s;
            mon_seen <= mon_seen_nxt;
            if (mon_edge)
                mon_cnt <= '0;
            else if (!mon_lost)
                mon_cnt <= mon_cnt + MW'(1);
        end
    end

    // An edge must be seen inside the current, uninterrupted qualification window
    assign mon_seen_nxt = (state_nxt == WAIT_LOCK) && (cnt_nxt != '0) && (mon_seen | mon_edge);
`else
    logic mon_lost, unused_mon;
    assign mon_lost   = 1'b0;
    assign qual_ok    = 1'b1;
    assign unused_mon = mon_toggle ^ (MON_CYCLES == 0);
`endif

    assign lost = !lock_s || mon_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HOLD;
            cnt          <= '0;
            idx          <= '0;
            rst_o        <= '1;
            ready        <= 1'b0;
            fault        <= 1'b0;
            lockloss_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            rst_o <= rst_nxt;
            ready <= ready_nxt;
            fault <= fault_nxt;
            if (count_loss && lockloss_cnt != 8'hFF)
                lockloss_cnt <= lockloss_cnt + 8'd1;
        end
    end

    // External reset outranks lock loss so a coincident event is not counted
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        fault_nxt  = fault;
        count_loss = 1'b0;
        if (ext_db) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else if (lost && (state == RELEASE || state == RUN)) begin
            state_nxt  = WAIT_LOCK;
            cnt_nxt    = '0;
            idx_nxt    = '0;
            fault_nxt  = 1'b1;
            count_loss = 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_nxt = '0;
                    end else if (cnt == CW'(STEP_CYCLES - 1)) begin
                        cnt_nxt = '0;
                        if (qual_ok) begin
                            state_nxt = RELEASE;
                            idx_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (idx == IW'(NRST)) begin
                        state_nxt = RUN;
                        fault_nxt = 1'b0;
                    end else if (cnt == CW'(STEP_CYCLES - 1)) begin
                        cnt_nxt = '0;
                        idx_nxt = idx + IW'(1);
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rst_nxt   = '1;
        ready_nxt = 1'b0;
        case (state_nxt)
            RELEASE: begin
                for (int k = 0; k < NRST; k++)
                    rst_nxt[k] = (k >= int'(idx_nxt));
            end
            RUN: begin
                rst_nxt   = '0;
                ready_nxt = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
